// File: rtl/dma_sched_pkg.sv
// ---------------------------------------------------------------------------
// dma_sched_pkg : shared types and constants for the DMA scheduler
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dma_sched_pkg;

  localparam int ADDR_SYS_W = 32;
  localparam int ADDR_C64_W = 24;
  localparam int CNT_W      = 16;

  localparam logic [ADDR_C64_W:0] C64_LIMIT = 25'h100_0000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    ISSUE     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    COMPLETE  = 3'd5
  } state_e;

  // True when the transfer would run past the top of the C64 address space.
  function automatic logic c64_overflow(input logic [ADDR_C64_W-1:0] dst,
                                        input logic [CNT_W-1:0]      cnt);
    logic [ADDR_C64_W:0] end_addr;
    end_addr = {1'b0, dst} + {{(ADDR_C64_W + 1 - CNT_W){1'b0}}, cnt};
    return end_addr > C64_LIMIT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_rr_arbiter.sv
// ---------------------------------------------------------------------------
// dma_rr_arbiter : combinational round-robin pick, search starts at ptr
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dma_rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [2:0]        ptr,
  output logic [2:0]        grant,
  output logic              any_pending
);

  logic [3:0] idx;

  // Walk the candidates from furthest to nearest so the nearest pending one wins.
  always_comb begin
    grant       = '0;
    any_pending = |pending;
    idx         = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(NUM_CH)) begin
        idx = idx - 4'(NUM_CH);
      end
      if ((pending & ({{(NUM_CH-1){1'b0}}, 1'b1} << idx)) != '0) begin
        grant = idx[2:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dma_scheduler.sv
// ---------------------------------------------------------------------------
// dma_scheduler : shares one DMA engine between NUM_CH descriptor slots.
//                 Optional watchdog: DMA_SCHED_TIMEOUT_EN (adds dma_abort).
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dma_scheduler
  import dma_sched_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                         clk_sys,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH*ADDR_SYS_W-1:0] req_src,
  input  logic [NUM_CH*ADDR_C64_W-1:0] req_dst,
  input  logic [NUM_CH*CNT_W-1:0]      req_count,
  input  logic [NUM_CH-1:0]            req_dir,
  output logic [NUM_CH-1:0]            chan_done,
  output logic [NUM_CH-1:0]            chan_err,
  output logic                         dma_start,
  output logic [ADDR_SYS_W-1:0]        src_addr,
  output logic [ADDR_C64_W-1:0]        dst_addr,
  output logic [CNT_W-1:0]             count,
  output logic                         direction,
  input  logic                         dma_busy,
  input  logic                         dma_done,
  output logic                         sched_busy,
`ifdef DMA_SCHED_TIMEOUT_EN
  output logic                         dma_abort,
`endif
  output logic [2:0]                   active_chan
);

  generate
    if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2097152) begin : g_param_check
      $error("dma_scheduler: parameter out of range");
    end
  endgenerate

  state_e                 state_q, state_d;
  logic [NUM_CH-1:0]      pending_q, pending_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [2:0]             active_chan_q, active_chan_d;
  logic [ADDR_SYS_W-1:0]  src_q [NUM_CH];
  logic [ADDR_SYS_W-1:0]  src_d [NUM_CH];
  logic [ADDR_C64_W-1:0]  dst_q [NUM_CH];
  logic [ADDR_C64_W-1:0]  dst_d [NUM_CH];
  logic [CNT_W-1:0]       cnt_q [NUM_CH];
  logic [CNT_W-1:0]       cnt_d [NUM_CH];
  logic [NUM_CH-1:0]      dir_q, dir_d;

  logic [NUM_CH-1:0]      accept;
  logic [2:0]             grant;
  logic                   any_pending;
  logic [NUM_CH-1:0]      grant_oh, active_oh;
  logic [ADDR_C64_W-1:0]  g_dst;
  logic [CNT_W-1:0]       g_cnt;
  logic [ADDR_SYS_W-1:0]  a_src;
  logic [ADDR_C64_W-1:0]  a_dst;
  logic [CNT_W-1:0]       a_cnt;
  logic                   a_dir;
  logic                   in_wait;

`ifdef DMA_SCHED_TIMEOUT_EN
  localparam logic [20:0] TMO_LIMIT = 21'(TIMEOUT_CYCLES);
  logic [20:0]            tmo_q, tmo_d;
`endif

  dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .pending     (pending_q),
    .ptr         (ptr_q),
    .grant       (grant),
    .any_pending (any_pending)
  );

  assign accept    = req_valid & ~pending_q;
  assign req_ready = ~pending_q;
  assign in_wait   = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);

  // Slot muxes for the arbitration winner and for the engine-owning channel.
  always_comb begin
    grant_oh  = '0;
    active_oh = '0;
    g_dst     = '0;
    g_cnt     = '0;
    a_src     = '0;
    a_dst     = '0;
    a_cnt     = '0;
    a_dir     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == 3'(i)) begin
        grant_oh[i] = 1'b1;
        g_dst       = dst_q[i];
        g_cnt       = cnt_q[i];
      end
      if (active_chan_q == 3'(i)) begin
        active_oh[i] = 1'b1;
        a_src        = src_q[i];
        a_dst        = dst_q[i];
        a_cnt        = cnt_q[i];
        a_dir        = dir_q[i];
      end
    end
  end

  assign dma_start   = (state_q == ISSUE);
  assign sched_busy  = (state_q == ISSUE) || in_wait || (state_q == COMPLETE);
  assign src_addr    = sched_busy ? a_src : '0;
  assign dst_addr    = sched_busy ? a_dst : '0;
  assign count       = sched_busy ? a_cnt : '0;
  assign direction   = sched_busy & a_dir;
  assign active_chan = active_chan_q;

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q | accept;
    ptr_d         = ptr_q;
    active_chan_d = active_chan_q;
    src_d         = src_q;
    dst_d         = dst_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    chan_done     = '0;
    chan_err      = '0;

    for (int i = 0; i < NUM_CH; i++) begin
      if (accept[i]) begin
        src_d[i] = req_src[i*ADDR_SYS_W +: ADDR_SYS_W];
        dst_d[i] = req_dst[i*ADDR_C64_W +: ADDR_C64_W];
        cnt_d[i] = req_count[i*CNT_W +: CNT_W];
        dir_d[i] = req_dir[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (any_pending) state_d = ARB;
      end
      ARB: begin
        state_d = IDLE;
        if (any_pending) begin
          active_chan_d = grant;
          ptr_d         = (grant == 3'(NUM_CH - 1)) ? 3'd0 : grant + 3'd1;
          // Degenerate descriptors are retired here; the engine never sees them.
          if (g_cnt == '0) begin
            chan_done = grant_oh;
            pending_d = pending_d & ~grant_oh;
          end else if (c64_overflow(g_dst, g_cnt)) begin
            chan_err  = grant_oh;
            pending_d = pending_d & ~grant_oh;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (dma_done)      state_d = COMPLETE;
        else if (dma_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (dma_done) state_d = COMPLETE;
      end
      COMPLETE: begin
        chan_done = active_oh;
        pending_d = pending_d & ~active_oh;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef DMA_SCHED_TIMEOUT_EN
    tmo_d     = tmo_q;
    dma_abort = 1'b0;
    if (state_q == ISSUE) begin
      tmo_d = '0;
    end else if (in_wait) begin
      tmo_d = tmo_q + 21'd1;
    end
    // A done pulse in the expiry cycle wins and completes normally.
    if (in_wait && !dma_done && (tmo_q + 21'd1 == TMO_LIMIT)) begin
      chan_err  = active_oh;
      dma_abort = 1'b1;
      pending_d = pending_d & ~active_oh;
      state_d   = IDLE;
    end
`endif
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      ptr_q         <= '0;
      active_chan_q <= '0;
      dir_q         <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        cnt_q[i] <= '0;
      end
`ifdef DMA_SCHED_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      ptr_q         <= ptr_d;
      active_chan_q <= active_chan_d;
      dir_q         <= dir_d;
      for (int i = 0; i < NUM_CH; i++) begin
        src_q[i] <= src_d[i];
        dst_q[i] <= dst_d[i];
        cnt_q[i] <= cnt_d[i];
      end
`ifdef DMA_SCHED_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: doc/dma_scheduler.md
Name: dma_scheduler

Overview:
- Shares the single C64-bus DMA engine between NUM_CH independent HPS requesters, each owning one descriptor slot.
- Captures descriptors, arbitrates round-robin and issues one transfer at a time.
- Drives the engine's start/src/dst/count/direction inputs, waits for its done pulse, then reports per-channel completion or error.
- Sits between the HPS register bridge and dma_engine.

Parameters:
- NUM_CH, 4, number of requester channels (2..8).
- TIMEOUT_CYCLES, 1048576, clk_sys cycles allowed from dma_start to dma_done (used only with the optional feature).

Ports:
- clk_sys  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_CH  per-channel descriptor valid
- req_ready  out  NUM_CH  per-channel slot empty
- req_src  in  NUM_CH*32  source address, channel i at [32i+31:32i]
- req_dst  in  NUM_CH*24  destination address, channel i at [24i+23:24i]
- req_count  in  NUM_CH*16  byte count
- req_dir  in  NUM_CH  0 Sys->C64, 1 C64->Sys
- chan_done  out  NUM_CH  one-cycle completion pulse
- chan_err  out  NUM_CH  one-cycle error pulse
- dma_start  out  1  one-cycle start pulse to engine
- src_addr  out  32  to engine
- dst_addr  out  24  to engine
- count  out  16  to engine
- direction  out  1  to engine
- dma_busy  in  1  from engine
- dma_done  in  1  from engine
- sched_busy  out  1  transfer in flight
- active_chan  out  3  channel currently owning the engine

Behaviour:
- Reset values:
  - All outputs are 0, except req_ready, which is all ones.
  - Pending slots are cleared, RR pointer = 0, state = IDLE.
- Reset mid-transfer: drops the transfer without any chan_done or chan_err.
- Descriptor capture:
  - Accept on req_valid[i] & req_ready[i]. Latch the descriptor and set pending[i].
  - req_ready[i] = ~pending[i], registered.
  - A slot frees the cycle after its chan_done/chan_err pulse. The earliest re-accept is the following cycle.
- States: IDLE -> ARB -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> COMPLETE -> IDLE.
  - IDLE: if any pending bit is set, go to ARB.
  - ARB: round-robin grant.
    - Search starts at ptr. The first pending channel wins.
    - Register active_chan. Set ptr = winner+1 mod NUM_CH.
  - ARB, zero-length descriptor: if the winner has count==0, pulse chan_done, clear pending and return to IDLE. The engine is never started, because its count-1 compare would underflow.
  - ARB, address overflow: if dst + count > 2^24 (25-bit compare), pulse chan_err, clear pending and return to IDLE. The engine is never started.
  - ISSUE:
    - dma_start = 1 for exactly one cycle.
    - src_addr, dst_addr, count and direction are driven from the granted slot.
    - These outputs hold stable until COMPLETE.
    - sched_busy = 1 from ISSUE through COMPLETE.
  - WAIT_BUSY: wait for dma_busy = 1, then go to WAIT_DONE.
  - WAIT_DONE: wait for dma_done = 1.
  - Done seen directly: dma_done = 1 while still in WAIT_BUSY is treated as completion and goes straight to COMPLETE.
  - COMPLETE: pulse chan_done[active_chan], clear pending, sched_busy = 0, go to IDLE.
- Latency: a descriptor accepted at cycle t into an idle scheduler gives IDLE at t+1, ARB at t+2 and dma_start at t+3.
- Simultaneous events:
  - A new accept on a non-active channel during a transfer is legal. It is queued for the next ARB.
  - A new accept on the active channel is impossible, because its ready is low.
- Fairness: with all channels continuously pending, grants rotate 0,1,2,3,0...

Optional Feature:
- Macro: DMA_SCHED_TIMEOUT_EN.
- Enabled:
  - A 21-bit counter clears in ISSUE and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES with no dma_done: pulse chan_err[active_chan] and output dma_abort (1-bit port, reset 0) for one cycle, clear pending, go to IDLE.
  - dma_done arriving in the same cycle as the timeout takes precedence, giving a normal completion.
- Disabled: the counter and the dma_abort port are absent, and the scheduler waits indefinitely.

Decomposition:
- Package dma_sched_pkg holds:
  - state enum, 3-bit: IDLE, ARB, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE.
  - width constants: ADDR_SYS_W = 32, ADDR_C64_W = 24, CNT_W = 16.
  - C64 address-space limit 2^24.
- Sub-module dma_rr_arbiter, parameterised NUM_CH:
  - Inputs: pending vector and ptr.
  - Outputs: grant index and any_pending, combinational.
- The scheduler FSM, slots and timeout stay in dma_scheduler.

Test Plan:
- Single channel: ch1 src=0x1000 dst=0x00C000 count=16 dir=0; engine model raises dma_busy 1 cycle after start and dma_done 20 cycles later -> dma_start at t+3 with those values, chan_done[1] one pulse, req_ready[1] high again the cycle after.
- Round-robin: all 4 channels loaded at once, repeated reload -> grant order 0,1,2,3,0,1; no channel granted twice before the others.
- Zero count: ch2 count=0 -> chan_done[2] pulse, dma_start never asserted.
- Overflow: ch0 dst=0xFFFFF0 count=0x20 -> chan_err[0], no dma_start; dst=0xFFFFF0 count=0x10 -> accepted and issued.
- Reset mid-transfer: assert rst in WAIT_DONE with ch3 pending -> all outputs 0, req_ready all ones, no chan_done or chan_err; the post-reset descriptor is issued normally.
- With DMA_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=64, engine never pulses done -> chan_err and dma_abort pulse 64 cycles after ISSUE; a done pulse in the same cycle as the timeout gives chan_done only.
